// File: rtl/psu_pkg.sv
// Shared types for the PSU rail sequencing logic: FSM states, fault codes,
// ADC width default and a small sizing helper.
package psu_pkg;

  localparam int PSU_ADC_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    SETTLE,
    ON,
    SHUTDOWN,
    FAULT
  } psu_state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_TIMEOUT = 2'd1,
    FLT_UV      = 2'd2
  } psu_fault_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating cycle counter with synchronous clear/enable and a terminal-count
// compare; shared by the ramp timeout, settle and off-delay phases.
module seq_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_tc,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_count <= '0;
    else if (i_clr)                     r_count <= '0;
    else if (i_en && (r_count != '1))   r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == i_tc);

endmodule

// File: rtl/rail_sequencer.sv
// Power-up/power-down sequencer for the PSU rails: ramps rails in index order
// gated on ADC power-good, shuts them down in reverse, and latches UV/timeout faults.
module rail_sequencer
  import psu_pkg::*;
#(
  parameter int N_RAILS        = 5,
  parameter int ADC_WIDTH      = PSU_ADC_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int OFF_DELAY      = 1000,
  parameter int UV_HYST        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           clear_fault,
  input  logic [N_RAILS*ADC_WIDTH-1:0]   vsample,
  input  logic [N_RAILS-1:0]             vvalid,
  input  logic [N_RAILS*ADC_WIDTH-1:0]   pg_thresh,
  output logic [N_RAILS-1:0]             rail_en,
  output logic                           busy,
  output logic                           all_good,
  output logic                           fault,
  output logic [1:0]                     fault_code,
  output logic [2:0]                     fault_rail
);

  localparam int TMAX = max3(TIMEOUT_CYCLES, SETTLE_CYCLES, OFF_DELAY);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] TC_TO  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TC_SET = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TC_OFF = TW'(OFF_DELAY - 1);
  localparam logic [2:0]    IDX_LAST = 3'(N_RAILS - 1);

  psu_state_e         r_state, w_state_nx;
  psu_fault_e         r_fault_code, w_code_nx;
  logic [2:0]         r_idx, w_idx_nx;
  logic [2:0]         r_fault_rail, w_frail_nx;
  logic [N_RAILS-1:0] r_rail_en, w_en_nx;
  logic               r_busy, r_all_good, r_fault;

  logic [N_RAILS-1:0] w_good, w_uv, w_uv_mask, w_uv_hit;
  logic [2:0]         w_uv_idx;
  logic               w_good_idx;
  logic               w_tmr_clr, w_tmr_en, w_tmr_tc;
  logic [TW-1:0]      w_tc_val;

  // Per-rail good/UV compare; UV threshold clamps at zero for small thresholds.
  for (genvar g = 0; g < N_RAILS; g++) begin : g_rail
    logic [ADC_WIDTH-1:0] w_s, w_t, w_uvt;
    assign w_s       = vsample[g*ADC_WIDTH +: ADC_WIDTH];
    assign w_t       = pg_thresh[g*ADC_WIDTH +: ADC_WIDTH];
    assign w_uvt     = (w_t >= ADC_WIDTH'(UV_HYST)) ? (w_t - ADC_WIDTH'(UV_HYST)) : '0;
    assign w_good[g] = vvalid[g] && (w_s >= w_t);
    assign w_uv[g]   = vvalid[g] && (w_s < w_uvt);
  end

  always_comb begin
    w_uv_mask = '0;
    for (int i = 0; i < N_RAILS; i++) begin
      case (r_state)
        RAMP:    w_uv_mask[i] = (3'(i) < r_idx);
        SETTLE:  w_uv_mask[i] = (3'(i) == r_idx);
        ON:      w_uv_mask[i] = 1'b1;
        default: w_uv_mask[i] = 1'b0;
      endcase
    end
  end

  assign w_uv_hit   = w_uv & w_uv_mask;
  assign w_good_idx = w_good[r_idx];

  // Lowest offending index wins.
  always_comb begin
    w_uv_idx = '0;
    for (int i = N_RAILS - 1; i >= 0; i--)
      if (w_uv_hit[i]) w_uv_idx = 3'(i);
  end

  always_comb begin
    case (r_state)
      RAMP:    w_tc_val = TC_TO;
      SETTLE:  w_tc_val = TC_SET;
      default: w_tc_val = TC_OFF;
    endcase
  end

  assign w_tmr_en = (r_state == RAMP) || (r_state == SETTLE) || (r_state == SHUTDOWN);

  seq_timer #(.W(TW)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .i_tc  (w_tc_val),
    .o_tc  (w_tmr_tc)
  );

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_en_nx    = r_rail_en;
    w_code_nx  = r_fault_code;
    w_frail_nx = r_fault_rail;
    w_tmr_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_state_nx = RAMP;
          w_idx_nx   = '0;
          w_en_nx    = N_RAILS'(1);
          w_tmr_clr  = 1'b1;
        end
      end
      RAMP, SETTLE, ON: begin
        if (|w_uv_hit) begin
          w_state_nx = FAULT;
          w_en_nx    = '0;
          w_code_nx  = FLT_UV;
          w_frail_nx = w_uv_idx;
        end else if ((r_state == RAMP) && !w_good_idx && w_tmr_tc) begin
          w_state_nx = FAULT;
          w_en_nx    = '0;
          w_code_nx  = FLT_TIMEOUT;
          w_frail_nx = r_idx;
        end else if (stop) begin
          // r_idx is always the highest enabled rail here.
          w_state_nx       = SHUTDOWN;
          w_en_nx[r_idx]   = 1'b0;
          w_tmr_clr        = 1'b1;
        end else if ((r_state == RAMP) && w_good_idx) begin
          w_state_nx = SETTLE;
          w_tmr_clr  = 1'b1;
        end else if ((r_state == SETTLE) && w_tmr_tc) begin
          if (r_idx == IDX_LAST) begin
            w_state_nx = ON;
          end else begin
            w_state_nx              = RAMP;
            w_idx_nx                = r_idx + 3'd1;
            w_en_nx[r_idx + 3'd1]   = 1'b1;
            w_tmr_clr               = 1'b1;
          end
        end
      end
      SHUTDOWN: begin
        if (w_tmr_tc) begin
          if (r_idx == '0) begin
            w_state_nx = IDLE;
          end else begin
            w_idx_nx              = r_idx - 3'd1;
            w_en_nx[r_idx - 3'd1] = 1'b0;
            w_tmr_clr             = 1'b1;
          end
        end
      end
      FAULT: begin
        if (clear_fault) begin
          w_state_nx = IDLE;
          w_idx_nx   = '0;
          w_code_nx  = FLT_NONE;
          w_frail_nx = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_rail_en    <= '0;
      r_fault_code <= FLT_NONE;
      r_fault_rail <= '0;
      r_busy       <= 1'b0;
      r_all_good   <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_rail_en    <= w_en_nx;
      r_fault_code <= w_code_nx;
      r_fault_rail <= w_frail_nx;
      r_busy       <= (w_state_nx == RAMP) || (w_state_nx == SETTLE) ||
                      (w_state_nx == SHUTDOWN);
      r_all_good   <= (w_state_nx == ON);
      r_fault      <= (w_state_nx == FAULT);
    end
  end

  assign rail_en    = r_rail_en;
  assign busy       = r_busy;
  assign all_good   = r_all_good;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign fault_rail = r_fault_rail;

endmodule

// File: tb/tb_rail_sequencer.sv
// Directed bench for rail_sequencer: reset, ramp-up, UV, timeout, shutdown,
// mid-ramp stop and mid-ramp reset, with hand-computed expectations.
module tb_rail_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear_fault;
  logic [59:0] vsample, pg_thresh;
  logic [4:0]  vvalid;
  logic [4:0]  rail_en;
  logic        busy, all_good, fault;
  logic [1:0]  fault_code;
  logic [2:0]  fault_rail;

  logic [11:0] tgt [5];
  int          cyc, n_asrt, n_fail;

  always #5 clk = ~clk;

  // Rail model: an enabled rail sits at its target level, a disabled one at 0.
  for (genvar i = 0; i < 5; i++) begin : g_model
    assign vsample[i*12 +: 12] = rail_en[i] ? tgt[i] : 12'd0;
  end
  assign pg_thresh = {5{12'd2000}};

  rail_sequencer #(
    .N_RAILS(5), .ADC_WIDTH(12), .TIMEOUT_CYCLES(50),
    .SETTLE_CYCLES(10), .OFF_DELAY(5), .UV_HYST(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear_fault(clear_fault),
    .vsample(vsample), .vvalid(vvalid), .pg_thresh(pg_thresh),
    .rail_en(rail_en), .busy(busy), .all_good(all_good), .fault(fault),
    .fault_code(fault_code), .fault_rail(fault_rail)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
      vvalid = (cyc % 4 == 0) ? 5'h1f : 5'h00;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asrt++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_en(input logic [4:0] v, input int lim, input string tag);
    int k;
    k = 0;
    while (rail_en !== v && k < lim) begin tick(1); k++; end
    chk(tag, 32'(rail_en), 32'(v));
  endtask

  task automatic wait_good(input int lim, input string tag);
    int k;
    k = 0;
    while (all_good !== 1'b1 && k < lim) begin tick(1); k++; end
    chk(tag, 32'(all_good), 1);
  endtask

  task automatic pulse_clear();
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
  endtask

  initial begin
    logic [4:0] prev;
    int last, steps, gap, c0, k;
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear_fault = 1'b0;
    vvalid = '0; cyc = 0; n_asrt = 0; n_fail = 0;
    for (int i = 0; i < 5; i++) tgt[i] = 12'd2100;

    // Reset state
    tick(2);
    chk("rst_en", 32'(rail_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_good", 32'(all_good), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_code", 32'(fault_code), 0);
    chk("rst_rail", 32'(fault_rail), 0);
    rst = 1'b0;
    tick(3);
    chk("idle_en", 32'(rail_en), 0);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0; tick(1);
    chk("startstop_en", 32'(rail_en), 0);
    chk("startstop_busy", 32'(busy), 0);

    // Normal power-up
    start = 1'b1; tick(1); start = 1'b0;
    chk("up_en0", 32'(rail_en), 1);
    chk("up_busy", 32'(busy), 1);
    prev = rail_en; last = cyc; steps = 0; k = 0;
    while (all_good !== 1'b1 && k < 300) begin
      tick(1); k++;
      if (rail_en !== prev) begin
        chk("up_step_val", 32'(rail_en), 32'({prev[3:0], 1'b1}));
        gap = cyc - last;
        chk("up_step_gap", 32'(gap >= 11 && gap <= 14), 1);
        prev = rail_en; last = cyc; steps++;
      end
    end
    chk("up_steps", 32'(steps), 4);
    chk("up_all_good", 32'(all_good), 1);
    chk("up_busy_lo", 32'(busy), 0);
    chk("up_en_all", 32'(rail_en), 31);

    // Undervoltage in ON: 1990 is inside hysteresis, 1980 is below it
    tgt[3] = 12'd1990;
    tick(12);
    chk("uv1990_fault", 32'(fault), 0);
    chk("uv1990_good", 32'(all_good), 1);
    k = 0;
    while (vvalid !== 5'h1f && k < 8) begin tick(1); k++; end
    tick(1);
    tgt[3] = 12'd1980;
    tick(3);
    chk("uv_pre_fault", 32'(fault), 0);
    tick(1);
    chk("uv_fault", 32'(fault), 1);
    chk("uv_code", 32'(fault_code), 2);
    chk("uv_rail", 32'(fault_rail), 3);
    chk("uv_en", 32'(rail_en), 0);
    chk("uv_good_lo", 32'(all_good), 0);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0; tick(1);
    chk("uv_latched", 32'(fault), 1);
    pulse_clear();
    chk("uv_clr_fault", 32'(fault), 0);
    chk("uv_clr_code", 32'(fault_code), 0);
    chk("uv_clr_rail", 32'(fault_rail), 0);
    tgt[3] = 12'd2100;

    // Ramp timeout on rail 2
    tgt[2] = 12'd1500;
    start = 1'b1; tick(1); start = 1'b0;
    wait_en(5'b00111, 100, "to_en2");
    c0 = cyc;
    k = 0;
    while (fault !== 1'b1 && k < 200) begin tick(1); k++; end
    chk("to_latency", 32'(cyc - c0), 50);
    chk("to_code", 32'(fault_code), 1);
    chk("to_rail", 32'(fault_rail), 2);
    chk("to_en", 32'(rail_en), 0);
    chk("to_busy", 32'(busy), 0);
    pulse_clear();
    chk("to_clr_code", 32'(fault_code), 0);
    chk("to_clr_fault", 32'(fault), 0);
    tgt[2] = 12'd2100;

    // Shutdown from ON
    start = 1'b1; tick(1); start = 1'b0;
    wait_good(300, "sd_up");
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("sd_en4", 32'(rail_en), 5'b01111);
    chk("sd_busy", 32'(busy), 1);
    chk("sd_good_lo", 32'(all_good), 0);
    tick(4);
    chk("sd_hold", 32'(rail_en), 5'b01111);
    start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
    chk("sd_en3", 32'(rail_en), 5'b00111);
    tick(5); chk("sd_en2", 32'(rail_en), 5'b00011);
    tick(5); chk("sd_en1", 32'(rail_en), 5'b00001);
    tick(5); chk("sd_en0", 32'(rail_en), 5'b00000);
    chk("sd_busy_tail", 32'(busy), 1);
    tick(5); chk("sd_idle_busy", 32'(busy), 0);

    // Stop during SETTLE of rail 1
    start = 1'b1; tick(1); start = 1'b0;
    wait_en(5'b00011, 100, "mr_en1");
    tick(6);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("mr_en_a", 32'(rail_en), 5'b00001);
    chk("mr_busy", 32'(busy), 1);
    tick(5); chk("mr_en_b", 32'(rail_en), 0);
    tick(5); chk("mr_idle", 32'(busy), 0);

    // Asynchronous reset during RAMP
    start = 1'b1; tick(1); start = 1'b0;
    wait_en(5'b00111, 100, "rr_en2");
    #2 rst = 1'b1;
    #1;
    chk("rr_en", 32'(rail_en), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_fault", 32'(fault), 0);
    #2 rst = 1'b0;
    tick(3);
    chk("rr_idle", 32'(rail_en), 0);
    start = 1'b1; tick(1); start = 1'b0;
    chk("rr_restart", 32'(rail_en), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
